iter_seq_ctrl: RTL and testbench

- Controller that sequences a multi-cycle iterative datapath (serial multiplier, accumulator, shift-based divider) through a fixed number of steps.
- Accepts a `go` request with an iteration count, then issues a one-cycle `load` to the datapath.
- Issues one `en` strobe per step, gated by datapath readiness, and holds `done` until the consumer returns `ack`.
- Sits between the top-level request/acknowledge logic and the datapath's `load`/`en` controls.

---
 rtl/iter_seq_ctrl.sv | 108 ++++++++++
 tb/tb_iter_seq_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_seq_ctrl.sv
// Step sequencer for multi-cycle iterative datapaths: load, N gated enables, then hold done until ack.
// Optional abort port and aborted flag when ITER_SEQ_CTRL_ABORT_EN is defined.
module iter_seq_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_go,
    input  logic [CNT_W-1:0] i_n_iter,
    input  logic             i_dp_ready,
    input  logic             i_ack,
`ifdef ITER_SEQ_CTRL_ABORT_EN
    input  logic             i_abort,
    output logic             o_aborted,
`endif
    output logic             o_load,
    output logic             o_en,
    output logic             o_last,
    output logic             o_done,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_iter
);

    typedef enum logic [1:0] {
        StStart   = 2'd0,
        StCompute = 2'd1,
        StWait    = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_iter;
    logic             w_abort;
    logic             w_load;
    logic             w_en;
    logic             w_last;

`ifdef ITER_SEQ_CTRL_ABORT_EN
    assign w_abort = i_abort && (r_state == StCompute);
`else
    assign w_abort = 1'b0;
`endif

    // Strobes are gated by reset so nothing reaches the datapath while rst is held.
    always_comb begin
        w_load = !i_rst && (r_state == StStart) && i_go;
        w_en   = !i_rst && (r_state == StCompute) && i_dp_ready && !w_abort;
        w_last = w_en && (r_iter == (r_cnt - CNT_W'(1)));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StStart;
            r_cnt   <= '0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                StStart: begin
                    if (i_go) begin
                        r_cnt   <= i_n_iter;
                        r_iter  <= '0;
                        r_state <= (i_n_iter != '0) ? StCompute : StWait;
                    end
                end
                StCompute: begin
                    if (w_abort) begin
                        r_state <= StWait;
                    end else if (w_en) begin
                        r_iter <= r_iter + CNT_W'(1);
                        if (w_last) begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (i_ack) begin
                        r_state <= StStart;
                    end
                end
                default: r_state <= StStart;
            endcase
        end
    end

`ifdef ITER_SEQ_CTRL_ABORT_EN
    logic r_aborted;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_aborted <= 1'b0;
        end else if (w_load) begin
            r_aborted <= 1'b0;
        end else if (w_abort) begin
            r_aborted <= 1'b1;
        end
    end

    assign o_aborted = r_aborted;
`endif

    assign o_load = w_load;
    assign o_en   = w_en;
    assign o_last = w_last;
    assign o_done = (r_state == StWait);
    assign o_busy = (r_state == StCompute) || (r_state == StWait);
    assign o_iter = r_iter;

endmodule

// File: tb/tb_iter_seq_ctrl.sv
// Directed, table-driven bench for iter_seq_ctrl; a hand-written max-length run covers n_iter=255.
// Abort vectors are included when ITER_SEQ_CTRL_ABORT_EN is defined.
module tb_iter_seq_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             go;
    logic [CNT_W-1:0] n_iter;
    logic             dp_ready;
    logic             ack;
    logic             load;
    logic             en;
    logic             last;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] iter;
    logic             abort;
    logic             aborted;

    int n_cmp;
    int n_bad;

    iter_seq_ctrl #(.CNT_W(CNT_W)) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_go       (go),
        .i_n_iter   (n_iter),
        .i_dp_ready (dp_ready),
        .i_ack      (ack),
`ifdef ITER_SEQ_CTRL_ABORT_EN
        .i_abort    (abort),
        .o_aborted  (aborted),
`endif
        .o_load     (load),
        .o_en       (en),
        .o_last     (last),
        .o_done     (done),
        .o_busy     (busy),
        .o_iter     (iter)
    );

`ifndef ITER_SEQ_CTRL_ABORT_EN
    assign aborted = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       go;
        logic [7:0] n;
        logic       rdy;
        logic       ack;
        logic       abt;
        logic       load;
        logic       en;
        logic       last;
        logic       done;
        logic       busy;
        logic [7:0] iter;
        logic       abd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string name, input logic r, input logic g, input logic [7:0] n,
                       input logic rdy, input logic a, input logic abt, input logic ld,
                       input logic e, input logic l, input logic d, input logic b,
                       input logic [7:0] it, input logic abd);
        vec_t v;
        v.name = name; v.rst = r; v.go = g; v.n = n; v.rdy = rdy; v.ack = a; v.abt = abt;
        v.load = ld; v.en = e; v.last = l; v.done = d; v.busy = b; v.iter = it; v.abd = abd;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [vec %0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic g, input logic [7:0] n, input logic rdy,
                         input logic a, input logic abt);
        rst = r; go = g; n_iter = n; dp_ready = rdy; ack = a; abort = abt;
    endtask

    initial begin
        int en_cnt;
        int last_cnt;
        int cyc;
        bit seen_done;

        n_cmp = 0;
        n_bad = 0;
        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // name            rst go n    rdy ack abt | load en last done busy iter abd
        add("rst_force0",  1, 1, 8'd4, 1, 0, 0,   0, 0, 0, 0, 0, 8'd0, 0);
        add("rst_force1",  1, 1, 8'd4, 1, 0, 0,   0, 0, 0, 0, 0, 8'd0, 0);
        // basic run n=4
        add("basic_c0",    0, 1, 8'd4, 1, 0, 0,   1, 0, 0, 0, 0, 8'd0, 0);
        add("basic_c1",    0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd0, 0);
        add("basic_c2",    0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd1, 0);
        add("basic_c3",    0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd2, 0);
        add("basic_c4",    0, 0, 8'd0, 1, 0, 0,   0, 1, 1, 0, 1, 8'd3, 0);
        add("basic_c5",    0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 1, 1, 8'd4, 0);
        add("basic_c6",    0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 1, 1, 8'd4, 0);
        add("basic_c7",    0, 0, 8'd0, 1, 1, 0,   0, 0, 0, 1, 1, 8'd4, 0);
        add("basic_c8",    0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 0, 0, 8'd4, 0);
        // stall n=3, dp_ready low in cycles 2-3
        add("stall_c0",    0, 1, 8'd3, 1, 0, 0,   1, 0, 0, 0, 0, 8'd4, 0);
        add("stall_c1",    0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd0, 0);
        add("stall_c2",    0, 0, 8'd0, 0, 0, 0,   0, 0, 0, 0, 1, 8'd1, 0);
        add("stall_c3",    0, 0, 8'd0, 0, 0, 0,   0, 0, 0, 0, 1, 8'd1, 0);
        add("stall_c4",    0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd1, 0);
        add("stall_c5",    0, 0, 8'd0, 1, 0, 0,   0, 1, 1, 0, 1, 8'd2, 0);
        add("stall_c6",    0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 1, 1, 8'd3, 0);
        add("stall_c7",    0, 0, 8'd0, 1, 1, 0,   0, 0, 0, 1, 1, 8'd3, 0);
        add("stall_c8",    0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 0, 0, 8'd3, 0);
        // zero count
        add("zero_c0",     0, 1, 8'd0, 1, 0, 0,   1, 0, 0, 0, 0, 8'd3, 0);
        add("zero_c1",     0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 1, 1, 8'd0, 0);
        add("zero_c2",     0, 0, 8'd0, 1, 1, 0,   0, 0, 0, 1, 1, 8'd0, 0);
        add("zero_c3",     0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 0, 0, 8'd0, 0);
        // ignored go/ack while busy, go+ack in WAIT ignored
        add("ign_c0",      0, 1, 8'd5, 1, 0, 0,   1, 0, 0, 0, 0, 8'd0, 0);
        add("ign_c1",      0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd0, 0);
        add("ign_c2",      0, 1, 8'd2, 1, 0, 0,   0, 1, 0, 0, 1, 8'd1, 0);
        add("ign_c3",      0, 0, 8'd2, 1, 1, 0,   0, 1, 0, 0, 1, 8'd2, 0);
        add("ign_c4",      0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd3, 0);
        add("ign_c5",      0, 0, 8'd0, 1, 0, 0,   0, 1, 1, 0, 1, 8'd4, 0);
        add("ign_c6",      0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 1, 1, 8'd5, 0);
        add("ign_c7",      0, 1, 8'd2, 1, 1, 0,   0, 0, 0, 1, 1, 8'd5, 0);
        add("ign_c8",      0, 1, 8'd2, 1, 0, 0,   1, 0, 0, 0, 0, 8'd5, 0);
        add("ign_c9",      0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd0, 0);
        add("ign_c10",     0, 0, 8'd0, 1, 0, 0,   0, 1, 1, 0, 1, 8'd1, 0);
        add("ign_c11",     0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 1, 1, 8'd2, 0);
        add("ign_c12",     0, 0, 8'd0, 1, 1, 0,   0, 0, 0, 1, 1, 8'd2, 0);
        add("ign_c13",     0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 0, 0, 8'd2, 0);
        // mid-run reset n=6
        add("mrst_c0",     0, 1, 8'd6, 1, 0, 0,   1, 0, 0, 0, 0, 8'd2, 0);
        add("mrst_c1",     0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd0, 0);
        add("mrst_c2",     0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd1, 0);
        add("mrst_c3",     1, 1, 8'd0, 1, 0, 0,   0, 0, 0, 0, 1, 8'd2, 0);
        add("mrst_c4",     0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 0, 0, 8'd0, 0);
        add("mrst_c5",     0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 0, 0, 8'd0, 0);
        add("mrst_c6",     0, 1, 8'd1, 1, 0, 0,   1, 0, 0, 0, 0, 8'd0, 0);
        add("mrst_c7",     0, 0, 8'd0, 1, 0, 0,   0, 1, 1, 0, 1, 8'd0, 0);
        add("mrst_c8",     0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 1, 1, 8'd1, 0);
        add("mrst_c9",     0, 0, 8'd0, 1, 1, 0,   0, 0, 0, 1, 1, 8'd1, 0);
        add("mrst_c10",    0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 0, 0, 8'd1, 0);
`ifdef ITER_SEQ_CTRL_ABORT_EN
        // abort n=8 in cycle 3; abort in WAIT ignored; aborted clears on next go
        add("abt_c0",      0, 1, 8'd8, 1, 0, 0,   1, 0, 0, 0, 0, 8'd1, 0);
        add("abt_c1",      0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd0, 0);
        add("abt_c2",      0, 0, 8'd0, 1, 0, 0,   0, 1, 0, 0, 1, 8'd1, 0);
        add("abt_c3",      0, 0, 8'd0, 1, 0, 1,   0, 0, 0, 0, 1, 8'd2, 0);
        add("abt_c4",      0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 1, 1, 8'd2, 1);
        add("abt_c5",      0, 0, 8'd0, 1, 0, 1,   0, 0, 0, 1, 1, 8'd2, 1);
        add("abt_c6",      0, 0, 8'd0, 1, 1, 0,   0, 0, 0, 1, 1, 8'd2, 1);
        add("abt_c7",      0, 0, 8'd0, 1, 0, 1,   0, 0, 0, 0, 0, 8'd2, 1);
        add("abt_c8",      0, 1, 8'd1, 1, 0, 0,   1, 0, 0, 0, 0, 8'd2, 1);
        add("abt_c9",      0, 0, 8'd0, 1, 0, 0,   0, 1, 1, 0, 1, 8'd0, 0);
        add("abt_c10",     0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 1, 1, 8'd1, 0);
        add("abt_c11",     0, 0, 8'd0, 1, 1, 0,   0, 0, 0, 1, 1, 8'd1, 0);
        add("abt_c12",     0, 0, 8'd0, 1, 0, 0,   0, 0, 0, 0, 0, 8'd1, 0);
`endif

        // Preamble reset, uncompared, so the table starts from a known state.
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].go, vq[i].n, vq[i].rdy, vq[i].ack, vq[i].abt);
            #1;
            chk({vq[i].name, ".load"}, i, {7'd0, load}, {7'd0, vq[i].load});
            chk({vq[i].name, ".en"},   i, {7'd0, en},   {7'd0, vq[i].en});
            chk({vq[i].name, ".last"}, i, {7'd0, last}, {7'd0, vq[i].last});
            chk({vq[i].name, ".done"}, i, {7'd0, done}, {7'd0, vq[i].done});
            chk({vq[i].name, ".busy"}, i, {7'd0, busy}, {7'd0, vq[i].busy});
            chk({vq[i].name, ".iter"}, i, iter, vq[i].iter);
`ifdef ITER_SEQ_CTRL_ABORT_EN
            chk({vq[i].name, ".aborted"}, i, {7'd0, aborted}, {7'd0, vq[i].abd});
`endif
        end

        // Maximum-length run: 255 steps, last only on the final en, done in cycle 256.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0);
        #1;
        chk("max.load", 0, {7'd0, load}, 8'd1);
        en_cnt = 0;
        last_cnt = 0;
        cyc = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
            cyc++;
            #1;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (en) en_cnt++;
                if (last) begin
                    last_cnt++;
                    chk("max.last_pos", cyc, 8'(en_cnt), 8'd255);
                end
            end
        end
        n_cmp++;
        if (!seen_done) begin
            n_bad++;
            $display("FAIL max.timeout: done not seen within %0d cycles, required by cycle 256", cyc);
        end
        chk("max.latency", 0, 8'(cyc - 1), 8'd255);
        chk("max.en_count", 0, 8'(en_cnt), 8'd255);
        chk("max.last_count", 0, 8'(last_cnt), 8'd1);
        chk("max.iter", 0, iter, 8'd255);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("max.done_clr", 0, {7'd0, done}, 8'd0);
        chk("max.busy_clr", 0, {7'd0, busy}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
